cyq_tt_scanner: RTL and testbench

Truth-table scanner that drives the three inputs (A, B, C) of a 3-input combinational block under test and samples its single output Y. It walks all eight input combinations, builds the 8-bit truth table, and compares it against an expected table. It sits between the board clock/switch logic and the combinational lab block, so that block can be self-checked in hardware.

---
 rtl/cyq_tt_scanner.sv | 99 +++++++++
 tb/tb_cyq_tt_scanner.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cyq_tt_scanner.sv
// cyq_tt_scanner: walks all 8 {a,b,c} vectors into a 3-input block, captures y as a truth table and checks it
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start              begins a scan when idle (level-sampled)
//   exp[7:0]           expected truth table, latched on an accepted start
//   y                  output of the block under test (asynchronous to clk)
//   a, b, c            registered drive of the current vector, a is the MSB of the index
//   busy, done         scan in progress / one-cycle result-valid pulse
//   pass, tt, err_idx, nerr   comparison results, held until the next accepted start
module cyq_tt_scanner #(
    parameter int SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] exp,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] tt,
    output logic [2:0] err_idx,
    output logic [3:0] nerr
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, REPORT} state_t;
    state_t     state_q, state_d;
    logic [1:0] sync_q, sync_d;
    logic [2:0] idx_q, idx_d, abc_q, abc_d, err_idx_q, err_idx_d, first_err;
    logic [3:0] cnt_q, cnt_d, nerr_q, nerr_d, pop_err;
    logic [7:0] tt_q, tt_d, exp_q, exp_d, diff;
    logic       done_q, done_d, pass_q, pass_d, accept;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            idx_q     <= '0;
            abc_q     <= '0;
            cnt_q     <= '0;
            tt_q      <= '0;
            exp_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_idx_q <= '0;
            nerr_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            idx_q     <= idx_d;
            abc_q     <= abc_d;
            cnt_q     <= cnt_d;
            tt_q      <= tt_d;
            exp_q     <= exp_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_idx_q <= err_idx_d;
            nerr_q    <= nerr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SETTLE : IDLE;
            SETTLE:  state_d = (cnt_q == 4'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
            SAMPLE:  state_d = (idx_q == 3'd7) ? REPORT : SETTLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        accept    = (state_q == IDLE) && start;
        diff      = tt_q ^ exp_q;
        pop_err   = '0;
        first_err = '0;
        for (int i = 7; i >= 0; i--) begin
            pop_err = pop_err + {3'd0, diff[i]};
            if (diff[i]) first_err = 3'(i);
        end
        sync_d    = {sync_q[0], y};
        exp_d     = accept ? exp : exp_q;
        idx_d     = accept ? 3'd0 : (state_q == SAMPLE && idx_q != 3'd7) ? idx_q + 3'd1 : idx_q;
        cnt_d     = (state_q == SETTLE) ? cnt_q + 4'd1 : 4'd0;
        abc_d     = (state_d == IDLE) ? 3'd0 : idx_d;
        tt_d      = accept ? 8'd0 : tt_q;
        if (state_q == SAMPLE) tt_d[idx_q] = sync_q[1];
        done_d    = (state_q == REPORT);
        pass_d    = accept ? 1'b0 : done_d ? (diff == 8'd0) : pass_q;
        err_idx_d = accept ? 3'd0 : done_d ? first_err : err_idx_q;
        nerr_d    = accept ? 4'd0 : done_d ? pop_err : nerr_q;
    end
    assign {a, b, c} = abc_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign pass      = pass_q;
    assign tt        = tt_q;
    assign err_idx   = err_idx_q;
    assign nerr      = nerr_q;
endmodule

// File: tb/tb_cyq_tt_scanner.sv
// tb_cyq_tt_scanner: scoreboard bench for cyq_tt_scanner with a majority-function block under test
module tb_cyq_tt_scanner;
    logic       clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0;
    logic [7:0] exp0 = '0, exp1 = '0;
    logic       a0, b0, c0, y0, busy0, done0, pass0;
    logic       a1, b1, c1, y1, busy1, done1, pass1;
    logic [7:0] tt0, tt1;
    logic [2:0] ei0, ei1;
    logic [3:0] n0, n1;
    int cyc = 0, errors = 0, checks = 0;

    typedef struct {logic [7:0] tt; logic p; logic [2:0] ei; logic [3:0] n; int at;} exp_t;
    typedef struct {logic [7:0] e; logic [7:0] tt; logic p; logic [2:0] ei; logic [3:0] n;} vec_t;
    exp_t q0[$], q1[$];
    vec_t v[4];

    assign y0 = (a0 & b0) | (a0 & c0) | (b0 & c0);
    assign y1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

    cyq_tt_scanner dut0 (.clk(clk), .rst_n(rst_n), .start(start0), .exp(exp0), .y(y0), .a(a0), .b(b0), .c(c0),
        .busy(busy0), .done(done0), .pass(pass0), .tt(tt0), .err_idx(ei0), .nerr(n0));
    cyq_tt_scanner #(.SETTLE_CYCLES(2)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .exp(exp1), .y(y1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1), .tt(tt1), .err_idx(ei1), .nerr(n1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            chk("d0 done pending", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("d0 tt", tt0, e.tt);
                chk("d0 pass", pass0, e.p);
                chk("d0 err_idx", ei0, e.ei);
                chk("d0 nerr", n0, e.n);
                chk("d0 done cycle", cyc, e.at);
                chk("d0 busy at done", busy0, 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            chk("d1 done pending", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("d1 tt", tt1, e.tt);
                chk("d1 pass", pass1, e.p);
                chk("d1 err_idx", ei1, e.ei);
                chk("d1 nerr", n1, e.n);
                chk("d1 done cycle", cyc, e.at);
            end
        end
    end

    task automatic launch0(input int k, input bit steps);
        @(posedge clk); #1;
        start0 = 1'b1;
        exp0   = v[k].e;
        q0.push_back('{v[k].tt, v[k].p, v[k].ei, v[k].n, cyc + 34});
        @(posedge clk); #1;
        start0 = 1'b0;
        exp0   = 8'h00;
        if (steps)
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                chk("d0 abc step", {a0, b0, c0}, 32'(i / 4));
                chk("d0 busy", busy0, 1);
            end
    endtask

    task automatic wait_done0();
        int n = 0;
        while (!done0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("d0 done within bound", 32'(n < 80), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        v[0] = '{8'hE8, 8'hE8, 1'b1, 3'd0, 4'd0};
        v[1] = '{8'hE9, 8'hE8, 1'b0, 3'd0, 4'd1};
        v[2] = '{8'h68, 8'hE8, 1'b0, 3'd7, 4'd1};
        v[3] = '{8'h17, 8'hE8, 1'b0, 3'd0, 4'd8};
        repeat (5) begin
            @(posedge clk); #1;
            start0 = 1'($urandom);
            start1 = 1'($urandom);
            exp0   = 8'($urandom);
        end
        @(negedge clk);
        chk("d0 reset outputs", {a0, b0, c0, busy0, done0, pass0, tt0, ei0, n0}, 0);
        chk("d1 reset outputs", {a1, b1, c1, busy1, done1, pass1, tt1, ei1, n1}, 0);
        start0 = 1'b0;
        start1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("d0 idle after reset", {a0, b0, c0, busy0, done0}, 0);
        launch0(0, 1'b1);
        wait_done0();
        chk("d0 pass held", pass0, 1);
        chk("d0 tt held", tt0, 8'hE8);
        for (int j = 1; j < 4; j++) begin
            launch0(j, 1'b0);
            wait_done0();
        end
        launch0(0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start0 = 1'b1;
        exp0   = 8'h00;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        start0 = 1'b1;
        exp0   = 8'h17;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done0();
        @(posedge clk); #1;
        k = cyc;
        start0 = 1'b1;
        exp0   = 8'hE8;
        for (int j = 1; j <= 3; j++) q0.push_back('{8'hE8, 1'b1, 3'd0, 4'd0, k + 34 * j});
        repeat (102) @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("d0 idle after held start", busy0, 0);
        launch0(0, 1'b0);
        repeat (18) @(negedge clk);
        chk("d0 abc before reset", {a0, b0, c0}, 3'b100);
        #1;
        rst_n = 1'b0;
        q0.delete();
        #1;
        chk("d0 mid-scan reset outputs", {a0, b0, c0, busy0, done0, pass0, tt0, ei0, n0}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        launch0(0, 1'b1);
        wait_done0();
        @(posedge clk); #1;
        start1 = 1'b1;
        exp1   = 8'hE8;
        q1.push_back('{8'hE8, 1'b1, 3'd0, 4'd0, cyc + 26});
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk("d1 abc step", {a1, b1, c1}, 32'(i / 3));
        end
        repeat (4) @(negedge clk);
        chk("d1 idle after scan", busy1, 0);
        chk("d0 queue drained", q0.size(), 0);
        chk("d1 queue drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
